// File: rtl/mem_bus_ctrl_if.sv
// Bus bundle between the core data port, the controller and the slave array.
// "master" is the core plus slaves environment, "slave" is the controller itself.
interface mem_bus_ctrl_if #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_REGIONS = 4
);
    logic                          cpu_req;
    logic                          cpu_we;
    logic [ADDR_W-1:0]             cpu_addr;
    logic [DATA_W-1:0]             cpu_wdata;
    logic [DATA_W-1:0]             cpu_rdata;
    logic                          cpu_stall;
    logic                          cpu_fault;
    logic [7:0]                    err_count;
    logic [NUM_REGIONS-1:0]        slv_sel;
    logic                          slv_we;
    logic [ADDR_W-1:0]             slv_addr;
    logic [DATA_W-1:0]             slv_wdata;
    logic [NUM_REGIONS*DATA_W-1:0] slv_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata,
        input  cpu_rdata, cpu_stall, cpu_fault, err_count,
               slv_sel, slv_we, slv_addr, slv_wdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata,
        output cpu_rdata, cpu_stall, cpu_fault, err_count,
               slv_sel, slv_we, slv_addr, slv_wdata
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Region-decoding bus controller with per-region wait states and fault counting.
// Optional MISALIGN_CHK_EN: requests with cpu_addr[1:0] != 0 fault like unmapped ones.
module mem_bus_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_REGIONS = 4,
    parameter int REGION_BITS = 2,
    parameter logic [4*(2**REGION_BITS)-1:0] WAIT_CFG = 16'h0102
) (
    input  logic         clk,
    input  logic         reset,
    mem_bus_ctrl_if.slave bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]             r_state;
    logic [3:0]             r_cnt;
    logic [7:0]             r_err;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic                   r_we;
    logic [REGION_BITS-1:0] r_region;

    logic [REGION_BITS-1:0] w_region;
    logic [3:0]             w_wait;
    logic                   w_misalign;
    logic                   w_reject;
    logic [REGION_BITS-1:0] w_idx;
    logic [NUM_REGIONS-1:0] w_sel;
    logic                   w_we;
    logic                   w_stall;
    logic                   w_fault;
    logic [ADDR_W-1:0]      w_addr;
    logic [DATA_W-1:0]      w_wdata;
    logic [DATA_W-1:0]      w_rdata;

    assign w_region = bus.cpu_addr[ADDR_W-1 -: REGION_BITS];
    assign w_wait   = WAIT_CFG[4*w_region +: 4];

`ifdef MISALIGN_CHK_EN
    assign w_misalign = |bus.cpu_addr[1:0];
`else
    assign w_misalign = 1'b0;
`endif

    assign w_reject = (int'(w_region) >= NUM_REGIONS) || w_misalign;

    // Reset forces every output low so nothing leaks to the slaves mid-abort.
    always_comb begin
        w_idx   = r_region;
        w_sel   = '0;
        w_we    = 1'b0;
        w_stall = 1'b0;
        w_fault = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_rdata = '0;
        if (!reset) begin
            if (r_state == S_IDLE) begin
                if (bus.cpu_req && w_reject) begin
                    w_fault = 1'b1;
                end else if (bus.cpu_req) begin
                    w_idx   = w_region;
                    w_sel   = NUM_REGIONS'(1) << w_region;
                    w_addr  = bus.cpu_addr;
                    w_wdata = bus.cpu_wdata;
                    if (w_wait == 4'd0) begin
                        w_we    = bus.cpu_we;
                        w_rdata = bus.slv_rdata[DATA_W*w_region +: DATA_W];
                    end else begin
                        w_stall = 1'b1;
                    end
                end
            end else begin
                w_sel   = NUM_REGIONS'(1) << r_region;
                w_addr  = r_addr;
                w_wdata = r_wdata;
                if (r_cnt != 4'd0) begin
                    w_stall = 1'b1;
                end else begin
                    w_we    = r_we;
                    w_rdata = bus.slv_rdata[DATA_W*w_idx +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_err    <= 8'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_region <= '0;
        end else if (r_state == S_IDLE) begin
            if (bus.cpu_req && w_reject) begin
                if (r_err != 8'hFF) r_err <= r_err + 8'd1;
            end else if (bus.cpu_req && w_wait != 4'd0) begin
                r_addr   <= bus.cpu_addr;
                r_wdata  <= bus.cpu_wdata;
                r_we     <= bus.cpu_we;
                r_region <= w_region;
                r_cnt    <= w_wait - 4'd1;
                r_state  <= S_WAIT;
            end
        end else begin
            if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            else               r_state <= S_IDLE;
        end
    end

    assign bus.cpu_rdata = w_rdata;
    assign bus.cpu_stall = w_stall;
    assign bus.cpu_fault = w_fault;
    assign bus.err_count = reset ? 8'd0 : r_err;
    assign bus.slv_sel   = w_sel;
    assign bus.slv_we    = w_we;
    assign bus.slv_addr  = w_addr;
    assign bus.slv_wdata = w_wdata;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomised bench for mem_bus_ctrl (3 regions populated, region 3 unmapped).
// Expectations come from a per-access "cycles left" model plus literal directed checks.
module tb_mem_bus_ctrl;
    localparam int NR = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_bus_ctrl_if #(.ADDR_W(32), .DATA_W(32), .NUM_REGIONS(NR)) bus ();

    mem_bus_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_REGIONS(NR), .REGION_BITS(2),
                   .WAIT_CFG(16'h0102)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_tot  = 0;
    int n_we   = 0;
    int m_we   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Wait per region straight from the configured nibbles: r0=2, r1=0, r2=1.
    int wt [4] = '{2, 0, 1, 0};

    // Model: an accepted access occupies W+1 cycles; 'left' counts those remaining.
    int          left  = 0;
    int          m_reg = 0;
    logic        m_wr  = 1'b0;
    logic [31:0] m_addr, m_wdata;
    int          m_err = 0;

    always @(negedge clk) begin
        logic [NR-1:0] e_sel;
        logic          e_stall, e_fault, e_we, rd_ok;
        logic [31:0]   e_addr, e_wdata, e_rdata;
        int            rg;
        logic          bad;
        e_sel = '0; e_stall = 0; e_fault = 0; e_we = 0; rd_ok = 0;
        e_addr = '0; e_wdata = '0; e_rdata = '0;
        if (bus.slv_we) n_we++;
        if (reset) begin
            left  = 0;
            m_err = 0;
            rd_ok = 1;
        end else begin
            if (left == 0 && bus.cpu_req) begin
                rg  = int'(bus.cpu_addr[31:30]);
                bad = (rg >= NR);
`ifdef MISALIGN_CHK_EN
                if (bus.cpu_addr[1:0] != 2'b00) bad = 1'b1;
`endif
                if (bad) begin
                    e_fault = 1;
                    rd_ok   = 1;
                end else begin
                    m_reg = rg; m_addr = bus.cpu_addr; m_wdata = bus.cpu_wdata;
                    m_wr  = bus.cpu_we; left = wt[rg] + 1;
                end
            end
            if (left > 0) begin
                e_sel   = NR'(1) << m_reg;
                e_addr  = m_addr;
                e_wdata = m_wdata;
                e_stall = (left > 1);
                if (left == 1) begin
                    e_we    = m_wr;
                    e_rdata = bus.slv_rdata[32*m_reg +: 32];
                    rd_ok   = 1;
                end
            end
        end
        chk("stall", 64'(bus.cpu_stall), 64'(e_stall));
        chk("fault", 64'(bus.cpu_fault), 64'(e_fault));
        chk("sel",   64'(bus.slv_sel),   64'(e_sel));
        chk("we",    64'(bus.slv_we),    64'(e_we));
        chk("err",   64'(bus.err_count), 64'(m_err));
        if (reset || e_sel != 0) begin
            chk("addr",  64'(bus.slv_addr),  64'(e_addr));
            chk("wdata", 64'(bus.slv_wdata), 64'(e_wdata));
        end
        if (rd_ok) chk("rdata", 64'(bus.cpu_rdata), 64'(e_rdata));
        if (bus.cpu_stall && bus.cpu_fault) chk("stall_and_fault", 64'd1, 64'd0);
        if (e_we) m_we++;
        if (left > 0) left--;
        if (e_fault && m_err < 255) m_err++;
    end

    task automatic cyc(input logic rq, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic rst);
        @(posedge clk);
        #1;
        reset         = rst;
        bus.cpu_req   = rq;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.slv_rdata = {$urandom, $urandom, $urandom};
        @(negedge clk);
        #1;
    endtask

    initial begin
        int n0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.slv_rdata = '0;
        @(negedge clk); #1;
        chk("rst_stall", 64'(bus.cpu_stall), 64'd0);
        chk("rst_sel",   64'(bus.slv_sel),   64'd0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("idle_sel", 64'(bus.slv_sel), 64'd0);

        // Zero-wait read from region 1
        @(posedge clk); #1;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h4000_0010;
        bus.slv_rdata = {32'hAAAA_0002, 32'h1234_5678, 32'hAAAA_0000};
        @(negedge clk); #1;
        chk("t1_stall", 64'(bus.cpu_stall), 64'd0);
        chk("t1_sel",   64'(bus.slv_sel),   64'b010);
        chk("t1_rdata", 64'(bus.cpu_rdata), 64'h1234_5678);

        // Two-wait write to region 0
        n0 = n_we;
        cyc(1, 1, 32'h0000_0020, 32'hDEAD_BEEF, 0);
        chk("t2_c1", {bus.cpu_stall, bus.slv_we, 1'b0, bus.slv_sel}, {1'b1, 1'b0, 1'b0, 3'b001});
        cyc(1, 1, 32'h0000_0020, 32'hDEAD_BEEF, 0);
        chk("t2_c2", {bus.cpu_stall, bus.slv_we, 1'b0, bus.slv_sel}, {1'b1, 1'b0, 1'b0, 3'b001});
        cyc(1, 1, 32'h0000_0020, 32'hDEAD_BEEF, 0);
        chk("t2_c3", {bus.cpu_stall, bus.slv_we, 1'b0, bus.slv_sel}, {1'b0, 1'b1, 1'b0, 3'b001});
        chk("t2_wdata", 64'(bus.slv_wdata), 64'hDEAD_BEEF);
        cyc(0, 0, 0, 0, 0);
        chk("t2_writes", 64'(n_we - n0), 64'd1);

        // Unmapped read
        cyc(1, 0, 32'hC000_0000, 0, 0);
        chk("t3_fault", 64'(bus.cpu_fault), 64'd1);
        chk("t3_sel",   64'(bus.slv_sel),   64'd0);
        chk("t3_rdata", 64'(bus.cpu_rdata), 64'd0);
        chk("t3_stall", 64'(bus.cpu_stall), 64'd0);
        chk("t3_err0",  64'(bus.err_count), 64'd0);
        cyc(0, 0, 0, 0, 0);
        chk("t3_err1",  64'(bus.err_count), 64'd1);

        // Reset during the second stall cycle of a write
        n0 = n_we;
        cyc(1, 1, 32'h0000_0040, 32'h0BAD_F00D, 0);
        cyc(1, 1, 32'h0000_0040, 32'h0BAD_F00D, 1);
        chk("t4_out", {bus.cpu_stall, bus.slv_we, bus.cpu_fault, bus.slv_sel}, 64'd0);
        chk("t4_rdata", 64'(bus.cpu_rdata), 64'd0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t4_sel", 64'(bus.slv_sel), 64'd0);
        chk("t4_err", 64'(bus.err_count), 64'd0);
        chk("t4_nowe", 64'(n_we - n0), 64'd0);

        // Misaligned read
        cyc(1, 0, 32'h0000_0022, 0, 0);
`ifdef MISALIGN_CHK_EN
        chk("t5_fault", 64'(bus.cpu_fault), 64'd1);
        chk("t5_sel",   64'(bus.slv_sel),   64'd0);
        cyc(0, 0, 0, 0, 0);
        chk("t5_err",   64'(bus.err_count), 64'd1);
`else
        chk("t5_c1", {bus.cpu_stall, bus.slv_sel}, {1'b1, 3'b001});
        chk("t5_addr", 64'(bus.slv_addr), 64'h22);
        cyc(1, 0, 32'h0000_0022, 0, 0);
        chk("t5_c2", {bus.cpu_stall, bus.slv_sel}, {1'b1, 3'b001});
        cyc(1, 0, 32'h0000_0022, 0, 0);
        chk("t5_c3", {bus.cpu_stall, bus.slv_sel}, {1'b0, 3'b001});
        chk("t5_addr3", 64'(bus.slv_addr), 64'h22);
`endif

        // Saturation of the fault counter
        for (int i = 0; i < 300; i++) cyc(1, 0, 32'hC000_0100, 0, 0);
        cyc(1, 0, 32'hC000_0100, 0, 0);
        chk("t6_err",   64'(bus.err_count), 64'd255);
        chk("t6_fault", 64'(bus.cpu_fault), 64'd1);

        // Random traffic, including address churn during stalls and rare resets
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(3) != 0) a[1:0] = 2'b00;
            cyc($urandom_range(9) < 7, 1'($urandom), a, $urandom, $urandom_range(99) == 0);
        end
        cyc(0, 0, 0, 0, 0);
        chk("total_writes", 64'(n_we), 64'(m_we));
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
